// File: rtl/div_pkg.sv
// Shared constants for the restoring divider: operand width, iteration count and ALU op codes.
package div_pkg;

   localparam int unsigned DIV_WIDTH = 32;
   localparam int unsigned DIV_ITER  = 32;

   localparam logic [5:0] OP_NOP  = 6'b000000;
   localparam logic [5:0] OP_SUBU = 6'b000010;

endpackage

// File: rtl/div_alu_step.sv
// One combinational restoring-divide iteration on the combined remainder/quotient register.
module div_alu_step
   import div_pkg::*;
#(
   parameter int unsigned WIDTH   = DIV_WIDTH,
   parameter logic [5:0]  OP_SUBU = div_pkg::OP_SUBU
) (
   input  logic [2*WIDTH-1:0] i_rem,
   input  logic [WIDTH-1:0]   i_divisor,
   input  logic [5:0]         i_subu_ctrl,
   output logic [2*WIDTH-1:0] o_rem_next,
   output logic               o_borrow
);

   logic [WIDTH-1:0] w_rem_hi;
   logic [WIDTH-1:0] w_rem_lo;
   logic [WIDTH:0]   w_diff;
   logic             w_unused;

   assign w_rem_hi = i_rem[2*WIDTH-1:WIDTH];
   assign w_rem_lo = i_rem[WIDTH-1:0];
   assign w_diff   = {1'b0, w_rem_hi} - {1'b0, i_divisor};

   // Bits that fall off the top on the shift are intentionally dropped.
   assign w_unused = ^{w_diff[WIDTH-1], i_rem[2*WIDTH-1]};

   always_comb begin
      o_borrow   = 1'b0;
      o_rem_next = {i_rem[2*WIDTH-2:0], 1'b0};
      if (i_subu_ctrl == OP_SUBU) begin
         o_borrow = w_diff[WIDTH];
         if (!w_diff[WIDTH]) begin
            o_rem_next = {w_diff[WIDTH-2:0], w_rem_lo, 1'b1};
         end
      end
   end

endmodule

// File: rtl/div_datapath.sv
// Restoring-divider datapath: remainder/quotient register driven by the control FSM strobes,
// plus a valid/ack holding stage for the finished result.
module div_datapath
   import div_pkg::*;
#(
   parameter int unsigned WIDTH   = DIV_WIDTH,
   parameter logic [5:0]  OP_SUBU = div_pkg::OP_SUBU
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   input  logic             w_ctrl,
   input  logic             sll_ctrl,
   input  logic [5:0]       subu_ctrl,
   input  logic             srl_ctrl,
   input  logic             ready,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero,
   output logic             out_valid,
   input  logic             out_ack
);

   logic [2*WIDTH-1:0] r_rem;
   logic [WIDTH-1:0]   r_divisor;
   logic               r_dbz;
   logic               r_ready_d;
   logic [WIDTH-1:0]   r_quotient;
   logic [WIDTH-1:0]   r_remainder;
   logic               r_dbz_out;
   logic               r_out_valid;

   logic [2*WIDTH-1:0] w_rem_next;
   logic               w_borrow;
   logic               w_publish;

   div_alu_step #(
      .WIDTH   (WIDTH),
      .OP_SUBU (OP_SUBU)
   ) u_alu_step (
      .i_rem       (r_rem),
      .i_divisor   (r_divisor),
      .i_subu_ctrl (subu_ctrl),
      .o_rem_next  (w_rem_next),
      .o_borrow    (w_borrow)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_rem     <= '0;
         r_divisor <= '0;
         r_dbz     <= 1'b0;
      end else if (w_ctrl) begin
         // Initial left shift is folded into the load.
         r_rem     <= {{(WIDTH-1){1'b0}}, dividend, 1'b0};
         r_divisor <= divisor;
         r_dbz     <= (divisor == '0);
      end else if (srl_ctrl) begin
         r_rem <= {1'b0, r_rem[2*WIDTH-1:WIDTH+1], r_rem[WIDTH-1:0]};
      end else if (sll_ctrl) begin
         r_rem <= w_rem_next;
      end
   end

   assign w_publish = ready & ~r_ready_d;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_ready_d   <= 1'b0;
         r_quotient  <= '0;
         r_remainder <= '0;
         r_dbz_out   <= 1'b0;
         r_out_valid <= 1'b0;
      end else begin
         r_ready_d <= ready;
         // A fresh result takes priority over a same-edge acknowledge.
         if (w_publish) begin
            r_quotient  <= r_rem[WIDTH-1:0];
            r_remainder <= r_rem[2*WIDTH-1:WIDTH];
            r_dbz_out   <= r_dbz;
            r_out_valid <= 1'b1;
         end else if (out_ack) begin
            r_out_valid <= 1'b0;
         end
      end
   end

   assign quotient    = r_quotient;
   assign remainder   = r_remainder;
   assign div_by_zero = r_dbz_out;
   assign out_valid   = r_out_valid;

endmodule

// File: tb/tb_div_datapath.sv
// Self-checking bench for div_datapath: drives FSM-like strobe sequences and checks results
// against a scoreboard of expected quotient/remainder/div_by_zero.
module tb_div_datapath;
   import div_pkg::*;

   localparam int W = DIV_WIDTH;

   typedef struct packed {
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         dbz;
   } exp_t;

   logic         clk;
   logic         reset_n;
   logic [W-1:0] dividend;
   logic [W-1:0] divisor;
   logic         w_ctrl;
   logic         sll_ctrl;
   logic [5:0]   subu_ctrl;
   logic         srl_ctrl;
   logic         ready;
   logic [W-1:0] quotient;
   logic [W-1:0] remainder;
   logic         div_by_zero;
   logic         out_valid;
   logic         out_ack;

   int   tests;
   int   fails;
   exp_t sb[$];

   div_datapath #(
      .WIDTH   (W),
      .OP_SUBU (OP_SUBU)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .dividend    (dividend),
      .divisor     (divisor),
      .w_ctrl      (w_ctrl),
      .sll_ctrl    (sll_ctrl),
      .subu_ctrl   (subu_ctrl),
      .srl_ctrl    (srl_ctrl),
      .ready       (ready),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero),
      .out_valid   (out_valid),
      .out_ack     (out_ack)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic test_reset();
      reset_n = 1'b0; dividend = '0; divisor = '0; w_ctrl = 0; sll_ctrl = 0;
      subu_ctrl = OP_NOP; srl_ctrl = 0; ready = 0; out_ack = 0;
      repeat (2) @(negedge clk);
      tests++; if (quotient !== '0) begin fails++; $display("FAIL reset_quotient got %h exp 0", quotient); end
      tests++; if (remainder !== '0) begin fails++; $display("FAIL reset_remainder got %h exp 0", remainder); end
      tests++; if (div_by_zero !== 1'b0) begin fails++; $display("FAIL reset_dbz got %b exp 0", div_by_zero); end
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b exp 0", out_valid); end
      reset_n = 1'b1;
      @(negedge clk);
   endtask

   // Full FSM-style sequence: load, DIV_ITER SUBU iterations, srl, idle, ready.
   task automatic run_division(input logic [W-1:0] a, input logic [W-1:0] b, input bit ack_at_ready,
                               input int hold, input bit ack_in_hold, input string name);
      exp_t e;
      exp_t got;
      e.q   = (b == '0) ? '1 : a / b;
      e.r   = (b == '0) ? a : a % b;
      e.dbz = (b == '0);
      sb.push_back(e);
      w_ctrl = 1'b1; dividend = a; divisor = b;
      @(negedge clk);
      w_ctrl = 1'b0; dividend = $urandom; divisor = $urandom;
      sll_ctrl = 1'b1; subu_ctrl = OP_SUBU;
      repeat (DIV_ITER) @(negedge clk);
      sll_ctrl = 1'b0; subu_ctrl = OP_NOP; srl_ctrl = 1'b1;
      @(negedge clk);
      srl_ctrl = 1'b0;
      @(negedge clk);
      ready = 1'b1; out_ack = ack_at_ready;
      @(negedge clk);
      out_ack = 1'b0;
      tests++;
      if (out_valid !== 1'b1) begin
         fails++; $display("FAIL %s_latency out_valid got %b exp 1", name, out_valid);
      end
      tests++;
      if (sb.size() == 0) begin
         fails++; $display("FAIL %s_scoreboard queue empty got 0 exp 1 entry", name);
      end else begin
         fails = fails;
         got = sb.pop_front();
         if ({quotient, remainder, div_by_zero} !== {got.q, got.r, got.dbz}) begin
            fails++;
            $display("FAIL %s_result got q=%h r=%h dbz=%b exp q=%h r=%h dbz=%b", name,
                     quotient, remainder, div_by_zero, got.q, got.r, got.dbz);
         end
      end
      for (int i = 0; i < hold; i++) begin
         if (ack_in_hold && i == 0) out_ack = 1'b1;
         @(negedge clk);
         out_ack = 1'b0;
         tests++;
         if (ack_in_hold) begin
            if (out_valid !== 1'b0) begin
               fails++; $display("FAIL %s_republish cycle %0d out_valid got %b exp 0", name, i, out_valid);
            end
         end else if ({out_valid, quotient, remainder, div_by_zero} !== {1'b1, e.q, e.r, e.dbz}) begin
            fails++;
            $display("FAIL %s_hold cycle %0d got v=%b q=%h r=%h exp v=1 q=%h r=%h", name, i,
                     out_valid, quotient, remainder, e.q, e.r);
         end
      end
      ready = 1'b0;
   endtask

   task automatic do_ack(input string name);
      logic [W-1:0] q_before;
      q_before = quotient;
      out_ack = 1'b1;
      @(negedge clk);
      out_ack = 1'b0;
      tests++;
      if (out_valid !== 1'b0) begin
         fails++; $display("FAIL %s_ack out_valid got %b exp 0", name, out_valid);
      end
      // Acknowledge with nothing valid must change nothing.
      out_ack = 1'b1;
      @(negedge clk);
      out_ack = 1'b0;
      tests++;
      if (out_valid !== 1'b0 || quotient !== q_before) begin
         fails++; $display("FAIL %s_idle_ack got v=%b q=%h exp v=0 q=%h", name, out_valid, quotient, q_before);
      end
   endtask

   task automatic test_basic();
      tests++;
      if (out_valid !== 1'b0) begin
         fails++; $display("FAIL basic_pre_valid got %b exp 0", out_valid);
      end
      run_division(32'd100, 32'd7, 1'b0, 0, 1'b0, "div_100_7");
      do_ack("div_100_7");
   endtask

   task automatic test_vectors();
      run_division(32'hFFFF_FFFF, 32'd1, 1'b0, 0, 1'b0, "div_ffff_1");
      do_ack("div_ffff_1");
      run_division(32'd5, 32'd9, 1'b0, 0, 1'b0, "div_5_9");
      do_ack("div_5_9");
      run_division(32'd123456789, 32'd1000, 1'b0, 0, 1'b0, "div_big");
      do_ack("div_big");
   endtask

   task automatic test_div_by_zero();
      run_division(32'd1234, 32'd0, 1'b0, 0, 1'b0, "div_by_zero");
      do_ack("div_by_zero");
   endtask

   task automatic test_hold_and_ready_high();
      run_division(32'd100, 32'd7, 1'b0, 10, 1'b0, "hold_no_ack");
      do_ack("hold_no_ack");
      run_division(32'd1000, 32'd3, 1'b0, 8, 1'b1, "ready_held");
   endtask

   task automatic test_back_to_back_ack();
      run_division(32'd200, 32'd6, 1'b0, 0, 1'b0, "b2b_first");
      // Second publish lands on the same edge as the acknowledge of the first.
      run_division(32'd77, 32'd5, 1'b1, 0, 1'b0, "b2b_pub_ack");
      do_ack("b2b_pub_ack");
   endtask

   task automatic test_reset_mid();
      run_division(32'd9, 32'd2, 1'b0, 0, 1'b0, "pre_reset");
      w_ctrl = 1'b1; dividend = 32'd100; divisor = 32'd7;
      @(negedge clk);
      w_ctrl = 1'b0; sll_ctrl = 1'b1; subu_ctrl = OP_SUBU;
      repeat (17) @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      tests++;
      if ({out_valid, quotient, remainder, div_by_zero} !== '0) begin
         fails++; $display("FAIL async_reset got v=%b q=%h r=%h dbz=%b exp all 0", out_valid, quotient,
                           remainder, div_by_zero);
      end
      sll_ctrl = 1'b0; subu_ctrl = OP_NOP;
      @(negedge clk);
      reset_n = 1'b1;
      repeat (3) @(negedge clk);
      tests++;
      if (out_valid !== 1'b0) begin
         fails++; $display("FAIL stale_publish out_valid got %b exp 0", out_valid);
      end
      run_division(32'd100, 32'd7, 1'b0, 0, 1'b0, "after_reset");
      do_ack("after_reset");
   endtask

   initial begin
      tests = 0;
      fails = 0;
      test_reset();
      test_basic();
      test_vectors();
      test_div_by_zero();
      test_hold_and_ready_high();
      test_back_to_back_ack();
      test_reset_mid();
      tests++;
      if (sb.size() != 0) begin
         fails++; $display("FAIL scoreboard_drain got %0d entries exp 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got no finish exp finish before 200000");
      $fatal(1, "timeout");
   end

endmodule
